// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM state encoding and op decode helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return !((op == MDU_MULT) || (op == MDU_MULTU));
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational conditional two's-complement negate of a W-bit value.
module mdu_cond_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_c_o
);

  assign y_c_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise divide requests are ignored.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;

  mdu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q;
  logic             neg_lo_q;

  logic             signed_op, sa, sb, accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    prod_fix;

  assign signed_op = op_is_signed(op);
  assign sa        = signed_op & srcA[WIDTH-1];
  assign sb        = signed_op & srcB[WIDTH-1];

  mdu_cond_neg #(.W(WIDTH)) u_abs_a (.a_i(srcA), .neg_i(sa), .y_c_o(abs_a));
  mdu_cond_neg #(.W(WIDTH)) u_abs_b (.a_i(srcB), .neg_i(sb), .y_c_o(abs_b));
  mdu_cond_neg #(.W(W2))    u_fix_prod (.a_i(acc_q), .neg_i(neg_lo_q), .y_c_o(prod_fix));

`ifdef MDU_DIV_EN
  logic             is_div_q, neg_hi_q, bzero_q;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept = (state_q == S_IDLE) && start;

  mdu_cond_neg #(.W(WIDTH)) u_fix_quo (.a_i(acc_q[WIDTH-1:0]),  .neg_i(neg_lo_q), .y_c_o(quo_fix));
  mdu_cond_neg #(.W(WIDTH)) u_fix_rem (.a_i(acc_q[W2-1:WIDTH]), .neg_i(neg_hi_q), .y_c_o(rem_fix));
`else
  assign accept   = (state_q == S_IDLE) && start && !op_is_div(op);
  assign div_zero = 1'b0;
`endif

  // One iteration: shift-add for multiply, restoring subtract for divide (acc = {rem, dividend/quotient}).
  always_comb begin
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    div_trial = acc_q[W2-1:WIDTH-1];
    div_ge    = (div_trial >= {1'b0, b_q});
    div_rem   = WIDTH'(div_ge ? (div_trial - {1'b0, b_q}) : div_trial);
    if (is_div_q) begin
      acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_lo_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MDU_DIV_EN
      div_zero <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q  <= S_CALC;
            busy     <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
            b_q      <= abs_b;
            neg_lo_q <= sa ^ sb;
`ifdef MDU_DIV_EN
            is_div_q <= op_is_div(op);
            neg_hi_q <= sa;
            bzero_q  <= (srcB == '0);
`endif
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q  <= S_DONE;
          done     <= 1'b1;
          {hi, lo} <= prod_fix;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            hi       <= rem_fix;
            lo       <= quo_fix;
            div_zero <= bzero_q;
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_hi, last_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); {eh, el} = p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
      2'b10: begin
        if (b == 32'd0) begin el = '1; eh = a; ez = 1'b1; end
        else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'd0) begin el = '1; eh = a; ez = 1'b1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit intrude);
    logic [31:0] eh, el;
    logic        ez, held, busy_ok;
    int          edges;
    model(o, a, b, eh, el, ez);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    edges = 0; held = 1'b1; busy_ok = 1'b1;
    while (!done && edges < 100) begin
      if (hi !== last_hi || lo !== last_lo) held = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (intrude && edges == 5) begin
        start = 1'b1; op = 2'(~o); srcA = $urandom; srcB = $urandom;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(edges), 64'd33);
    chk({tag, " hold"}, 64'(held), 64'd1);
    chk({tag, " busy"}, 64'({busy_ok, busy}), 64'b11);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " dz"}, 64'(div_zero), 64'(ez));
    @(posedge clk); #1;
    chk({tag, " post"}, 64'({busy, done, div_zero}), 64'd0);
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {29'd0, busy, done, div_zero, hi}, 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;
    last_hi = '0; last_lo = '0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1'b0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd7,        "mult_neg", 1'b0);
    run_op(2'b00, 32'h80000000, 32'h80000000, "mult_min", 1'b0);
    run_op(2'b00, 32'd12345,    32'hFFFF0000, "mult_intr", 1'b1);

    // Synchronous reset in the middle of a MULT.
    start = 1'b1; op = 2'b00; srcA = 32'h12345678; srcB = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid", {29'd0, busy, done, div_zero, hi}, 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);
    last_hi = '0; last_lo = '0;
    run_op(2'b01, 32'd5, 32'd6, "multu_5x6", 1'b0);

`ifdef MDU_DIV_EN
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,        "div_neg", 1'b0);
    run_op(2'b11, 32'd100,      32'd7,        "divu", 1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0);
    run_op(2'b11, 32'd100,      32'd0,        "divu_zero", 1'b0);
    run_op(2'b10, 32'hFFFFFF9C, 32'd0,        "div_zero", 1'b0);
`else
    // Divide requests must be dropped when no divider is built.
    start = 1'b1; op = 2'b10; srcA = 32'd100; srcB = 32'd7;
    repeat (3) begin
      @(posedge clk); #1;
      chk("nodiv busy", 64'({busy, done, div_zero}), 64'd0);
    end
    chk("nodiv hi", 64'(hi), 64'(last_hi));
    chk("nodiv lo", 64'(lo), 64'(last_lo));
    start = 1'b0;
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 20; i++) begin
`ifdef MDU_DIV_EN
      ro = 2'($urandom_range(0, 3));
`else
      ro = 2'($urandom_range(0, 1));
`endif
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($signed(16'($urandom)));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op(ro, ra, rb, $sformatf("rand%0d", i), (i % 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
